// File: rtl/wb_ram_slave_pkg.sv
// Shared widths and the queued request entry for the
// Wishbone RAM slave.
package wbram_pkg;
  localparam int DW   = 32;
  localparam int SELW = 4;
  localparam int IDXW = 30;

  typedef struct packed {
    logic            we;
    logic [IDXW-1:0] idx;
    logic [DW-1:0]   data;
    logic [SELW-1:0] sel;
    logic            bad;
  } req_t;
endpackage

// File: rtl/wb_ram_slave_if.sv
// Pipelined Wishbone-style request/response bundle
// between a bus master and the RAM slave.
interface wb_ram_slave_if;
  import wbram_pkg::*;

  logic            cyc;
  logic            stb__ENA;
  logic            stb_we;
  logic [31:0]     stb_addr;
  logic [DW-1:0]   stb_data;
  logic [SELW-1:0] stb_sel;
  logic            stb__RDY;
  logic            hold;
  logic            ack;
  logic            err;
  logic            stall;
  logic [DW-1:0]   rdata;
  logic            ack__RDY;
  logic            err__RDY;
  logic            stall__RDY;

  modport master (
    output cyc, stb__ENA, stb_we, stb_addr,
    output stb_data, stb_sel, hold,
    input  stb__RDY, ack, err, stall, rdata,
    input  ack__RDY, err__RDY, stall__RDY
  );

  modport slave (
    input  cyc, stb__ENA, stb_we, stb_addr,
    input  stb_data, stb_sel, hold,
    output stb__RDY, ack, err, stall, rdata,
    output ack__RDY, err__RDY, stall__RDY
  );
endinterface

// File: rtl/wb_ram_slave_fifo.sv
// In-order request queue; flush drops every entry
// without touching the storage array.
module wb_req_fifo
  import wbram_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  logic pop,
  input  logic flush,
  input  req_t din,
  output logic full,
  output logic empty,
  output req_t head
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] ONE = 1;
  localparam logic [PW:0]   CAP = DEPTH[PW:0];

  req_t           store [DEPTH];
  logic [PW-1:0]  rptr;
  logic [PW-1:0]  wptr;
  logic [PW:0]    count;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == CAP);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = store[rptr];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + ONE;
      if (do_pop)  rptr <= rptr + ONE;
      count <= count
             + {{PW{1'b0}}, do_push}
             - {{PW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) store[wptr] <= din;
  end
endmodule

// File: rtl/wb_ram_slave.sv
// Word RAM behind a request queue: one request
// served per cycle, ack/err one cycle after the pop.
module wb_ram_slave
  import wbram_pkg::*;
#(
  parameter int AW    = 4,
  parameter int DEPTH = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  wb_ram_slave_if.slave bus
);
  logic [DW-1:0] mem [2**AW];

  req_t          din;
  req_t          head;
  logic          full;
  logic          empty;
  logic          accept;
  logic          pop;
  logic          bad;
  logic [AW-1:0] widx;
  logic          unused_idx;

  assign bus.stb__RDY   = bus.cyc && !full;
  assign bus.stall      = !bus.stb__RDY;
  assign bus.ack__RDY   = 1'b1;
  assign bus.err__RDY   = 1'b1;
  assign bus.stall__RDY = 1'b1;

  assign bad = (|bus.stb_addr[31:AW+2])
            || (|bus.stb_addr[1:0]);

  assign accept = bus.stb__ENA && bus.stb__RDY;
  // gated by nRST so a reset edge never lands a write
  assign pop    = nRST && !empty
               && bus.cyc && !bus.hold;

  assign din.we   = bus.stb_we;
  assign din.idx  = bus.stb_addr[31:2];
  assign din.data = bus.stb_data;
  assign din.sel  = bus.stb_sel;
  assign din.bad  = bad;

  assign widx       = head.idx[AW-1:0];
  assign unused_idx = ^head.idx[IDXW-1:AW];

  wb_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (nRST),
    .push  (accept),
    .pop   (pop),
    .flush (!bus.cyc),
    .din   (din),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  always_ff @(posedge CLK) begin
    if (pop && head.we && !head.bad) begin
      for (int i = 0; i < SELW; i++) begin
        if (head.sel[i])
          mem[widx][8*i +: 8] <= head.data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      bus.ack   <= 1'b0;
      bus.err   <= 1'b0;
      bus.rdata <= '0;
    end else begin
      bus.ack   <= pop && !head.bad;
      bus.err   <= pop && head.bad;
      bus.rdata <= (pop && !head.bad && !head.we)
                 ? mem[widx] : '0;
    end
  end
endmodule

// File: tb/tb_wb_ram_slave.sv
// Directed-vector bench for wb_ram_slave with
// hand-computed responses and read data.
module tb_wb_ram_slave;
  logic clk;
  logic nrst;
  int   nvec;
  int   nerr;

  wb_ram_slave_if bus ();

  wb_ram_slave #(
    .AW    (4),
    .DEPTH (2)
  ) dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic we,
                       input logic [31:0] a,
                       input logic [31:0] d,
                       input logic [3:0] s);
    bus.stb__ENA = 1'b1;
    bus.stb_we   = we;
    bus.stb_addr = a;
    bus.stb_data = d;
    bus.stb_sel  = s;
  endtask

  // single request at 2-cycle latency; returns at the
  // negedge where its response should be visible
  task automatic req(input logic we,
                     input logic [31:0] a,
                     input logic [31:0] d,
                     input logic [3:0] s);
    drive(we, a, d, s);
    @(negedge clk);
    bus.stb__ENA = 1'b0;
    chk("lat_ack", {31'b0, bus.ack}, 32'h0);
    chk("lat_err", {31'b0, bus.err}, 32'h0);
    @(negedge clk);
  endtask

  task automatic rsp(input string tag,
                     input logic a, input logic e,
                     input logic [31:0] rd);
    chk({tag, "_ack"}, {31'b0, bus.ack}, {31'b0, a});
    chk({tag, "_err"}, {31'b0, bus.err}, {31'b0, e});
    chk({tag, "_rd"}, bus.rdata, rd);
  endtask

  initial begin
    nvec = 0;
    nerr = 0;
    nrst = 1'b0;
    bus.cyc      = 1'b0;
    bus.hold     = 1'b0;
    bus.stb__ENA = 1'b0;
    bus.stb_we   = 1'b0;
    bus.stb_addr = '0;
    bus.stb_data = '0;
    bus.stb_sel  = '0;

    // reset state
    @(negedge clk);
    @(negedge clk);
    rsp("rst", 1'b0, 1'b0, 32'h0);
    chk("rst_rdy0", {31'b0, bus.stb__RDY}, 32'h0);
    chk("rst_stall0", {31'b0, bus.stall}, 32'h1);
    bus.cyc = 1'b1;
    #1;
    chk("rst_rdy1", {31'b0, bus.stb__RDY}, 32'h1);
    chk("rst_stall1", {31'b0, bus.stall}, 32'h0);
    chk("const_rdy", {29'b0, bus.ack__RDY,
        bus.err__RDY, bus.stall__RDY}, 32'h7);
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);

    // full write then read back
    req(1'b1, 32'h8, 32'hA5A5_A5A5, 4'hF);
    rsp("wr8", 1'b1, 1'b0, 32'h0);
    req(1'b0, 32'h8, 32'h0, 4'hF);
    rsp("rd8", 1'b1, 1'b0, 32'hA5A5_A5A5);
    @(negedge clk);
    rsp("pulse", 1'b0, 1'b0, 32'h0);

    // byte-lane writes
    req(1'b1, 32'h8, 32'h0000_1234, 4'h3);
    rsp("wrlo", 1'b1, 1'b0, 32'h0);
    req(1'b0, 32'h8, 32'h0, 4'hF);
    rsp("rdlo", 1'b1, 1'b0, 32'hA5A5_1234);
    req(1'b1, 32'h8, 32'hBEEF_0000, 4'hC);
    req(1'b0, 32'h8, 32'h0, 4'hF);
    rsp("rdhi", 1'b1, 1'b0, 32'hBEEF_1234);

    // bad addresses: out of range, misaligned, aliasing write
    req(1'b0, 32'h40, 32'h0, 4'hF);
    rsp("bad40", 1'b0, 1'b1, 32'h0);
    req(1'b0, 32'h6, 32'h0, 4'hF);
    rsp("bad6", 1'b0, 1'b1, 32'h0);
    req(1'b1, 32'h48, 32'hFFFF_FFFF, 4'hF);
    rsp("bad48", 1'b0, 1'b1, 32'h0);
    req(1'b0, 32'h8, 32'h0, 4'hF);
    rsp("noalias", 1'b1, 1'b0, 32'hBEEF_1234);

    // top word
    req(1'b1, 32'h3C, 32'hDEAD_BEEF, 4'hF);
    req(1'b0, 32'h3C, 32'h0, 4'hF);
    rsp("rd3c", 1'b1, 1'b0, 32'hDEAD_BEEF);

    // back-to-back reads: push and pop in one cycle
    drive(1'b0, 32'h8, 32'h0, 4'hF);
    @(negedge clk);
    chk("b2b_rdy", {31'b0, bus.stb__RDY}, 32'h1);
    drive(1'b0, 32'h3C, 32'h0, 4'hF);
    @(negedge clk);
    bus.stb__ENA = 1'b0;
    rsp("b2b0", 1'b1, 1'b0, 32'hBEEF_1234);
    chk("b2b_stall", {31'b0, bus.stall}, 32'h0);
    @(negedge clk);
    rsp("b2b1", 1'b1, 1'b0, 32'hDEAD_BEEF);

    // hold: queue fills, stall, then in-order drain
    bus.hold = 1'b1;
    drive(1'b0, 32'h8, 32'h0, 4'hF);
    @(negedge clk);
    chk("hold_st1", {31'b0, bus.stall}, 32'h0);
    drive(1'b0, 32'h3C, 32'h0, 4'hF);
    @(negedge clk);
    bus.stb__ENA = 1'b0;
    chk("hold_st2", {31'b0, bus.stall}, 32'h1);
    rsp("hold_q2", 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("hold_st3", {31'b0, bus.stall}, 32'h1);
    rsp("hold_q3", 1'b0, 1'b0, 32'h0);
    bus.hold = 1'b0;
    @(negedge clk);
    rsp("drain0", 1'b1, 1'b0, 32'hBEEF_1234);
    chk("drain_st", {31'b0, bus.stall}, 32'h0);
    @(negedge clk);
    rsp("drain1", 1'b1, 1'b0, 32'hDEAD_BEEF);
    @(negedge clk);
    rsp("drain2", 1'b0, 1'b0, 32'h0);

    // cyc drop flushes two queued writes
    bus.hold = 1'b1;
    drive(1'b1, 32'h8, 32'h0, 4'hF);
    @(negedge clk);
    drive(1'b1, 32'h3C, 32'h0, 4'hF);
    @(negedge clk);
    bus.stb__ENA = 1'b0;
    bus.cyc = 1'b0;
    @(negedge clk);
    rsp("flush0", 1'b0, 1'b0, 32'h0);
    chk("flush_rdy", {31'b0, bus.stb__RDY}, 32'h0);
    bus.cyc  = 1'b1;
    bus.hold = 1'b0;
    #1;
    chk("flush_empty", {31'b0, bus.stall}, 32'h0);
    @(negedge clk);
    rsp("flush1", 1'b0, 1'b0, 32'h0);
    req(1'b0, 32'h8, 32'h0, 4'hF);
    rsp("fl_rd8", 1'b1, 1'b0, 32'hBEEF_1234);
    req(1'b0, 32'h3C, 32'h0, 4'hF);
    rsp("fl_rd3c", 1'b1, 1'b0, 32'hDEAD_BEEF);

    // reset with pending write and read
    bus.hold = 1'b1;
    drive(1'b1, 32'h3C, 32'h0, 4'hF);
    @(negedge clk);
    drive(1'b0, 32'h8, 32'h0, 4'hF);
    @(negedge clk);
    bus.stb__ENA = 1'b0;
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    bus.hold = 1'b0;
    rsp("prst0", 1'b0, 1'b0, 32'h0);
    chk("prst_rdy", {31'b0, bus.stb__RDY}, 32'h1);
    @(negedge clk);
    rsp("prst1", 1'b0, 1'b0, 32'h0);
    req(1'b0, 32'h3C, 32'h0, 4'hF);
    rsp("prst_rd", 1'b1, 1'b0, 32'hDEAD_BEEF);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end
endmodule

// File: doc/wb_ram_slave.md
WB_RAM_SLAVE -- requirements
Module: wb_ram_slave

Interface
REQ-001 Parameter AW, default 4: word-address bits; memory holds 2**AW 32-bit words.
REQ-002 Parameter DEPTH, default 2: request FIFO entries; power of two, at least 2.
REQ-003 CLK  input  1  clock; all state updates on posedge.
REQ-004 nRST  input  1  reset; synchronous, active-low; clock CLK.
REQ-005 cyc  input  1  bus cycle active; low flushes pending work.
REQ-006 stb__ENA  input  1  request strobe from upstream arbiter output port.
REQ-007 stb$we  input  1  1 = write, 0 = read.
REQ-008 stb$addr  input  32  byte address; bits [AW+1:2] select the word.
REQ-009 stb$data  input  32  write data.
REQ-010 stb$sel  input  4  byte enables; bit i covers data[8i+7:8i].
REQ-011 stb__RDY  output  1  request acceptable this cycle.
REQ-012 hold  input  1  external memory-port busy; blocks servicing.
REQ-013 ack  output  1  one-cycle success response, one per accepted good request.
REQ-014 err  output  1  one-cycle error response, one per accepted bad request.
REQ-015 stall  output  1  pipeline stall to master.
REQ-016 rdata  output  32  read data, valid while ack is high after a read.
REQ-017 ack__RDY, err__RDY, stall__RDY  output  1 each  constant 1.

Function
REQ-018 stb__RDY SHALL equal cyc && !full; stall SHALL equal !stb__RDY.
REQ-019 A request is accepted when stb__ENA && stb__RDY; it SHALL push {we, word index, data, sel, bad} into the FIFO at that posedge.
REQ-020 bad SHALL be 1 when stb$addr[31:AW+2] != 0 or stb$addr[1:0] != 0.
REQ-021 When the FIFO is non-empty, cyc=1 and hold=0, the head SHALL pop at the posedge.
REQ-022 The FIFO SHALL serve requests in order, one per cycle.
REQ-023 Popped good write SHALL update only the bytes enabled by sel, at that posedge.
REQ-024 Popped bad request SHALL leave memory unchanged.
REQ-025 ack or err SHALL be registered at the pop posedge and high for exactly the following cycle.
REQ-026 Minimum latency SHALL be 2 cycles: accept edge N, pop edge N+1, ack/err high in cycle N+1..N+2.
REQ-027 Read rdata SHALL be the memory word as of the pop edge, including writes popped earlier.
REQ-028 rdata SHALL be 0 in cycles where ack is low or the ack was for a write.
REQ-029 Push and pop in the same cycle SHALL leave the count unchanged.
REQ-030 full SHALL mean count == DEPTH; accepting when full is impossible by REQ-018.
REQ-031 hold=1 SHALL freeze the FIFO head; a push is still allowed while not full.
REQ-032 cyc=0 SHALL clear the FIFO count and discard pending writes with no memory update and no responses.
REQ-033 ack and err SHALL be 0 in the cycle after any edge with cyc=0.
REQ-034 ack and err SHALL never be high simultaneously.

Reset
REQ-035 With nRST=0 at posedge: FIFO count, read and write pointers, ack, err and rdata SHALL be 0; memory contents unchanged.
REQ-036 Reset mid-operation SHALL drop all pending requests without a response or memory write.
REQ-037 stb__RDY SHALL follow REQ-018 combinationally during reset.

Structure
REQ-038 Package wbram_pkg SHALL hold the data width (32), SELW (4) and the request-entry struct typedef {we, idx, data, sel, bad}.
REQ-039 FIFO SHALL be sub-module wb_req_fifo(DEPTH) with push/pop/flush, full/empty and head outputs.
REQ-040 Memory, decode and response registers SHALL live in the top level.

Verification
REQ-041 Write addr 0x8, data 0xA5A5A5A5, sel 0xF, then read 0x8 -> ack on each at 2-cycle latency; read rdata = 0xA5A5A5A5.
REQ-042 Word 0x8 = 0xA5A5A5A5; write data 0x00001234 with sel 0x3; read -> rdata = 0xA5A51234.
REQ-043 Read addr 0x40 (AW=4) and addr 0x6 -> err pulses, ack stays 0, memory unchanged.
REQ-044 hold=1 with back-to-back stb -> stall rises after 2 accepts; release hold -> 2 acks on consecutive cycles, in order.
REQ-045 Two writes queued under hold; drop cyc for one cycle -> no ack/err, memory unchanged, FIFO empty.
REQ-046 nRST pulse with 1 pending read -> no response; ack=err=0, stb__RDY=cyc after reset.
